// File: rtl/line_option_feeder_if.sv
// line_option_feeder_if
//   Bundles the board-parser load port, the solver issue/response port, the
//   status flags and the debug view of the feeder FSM.
//
//   Handshake rules:
//     load_valid/load_ready : a token transfers on a rising edge where both
//                             are high; a token offered while the queue is
//                             full is dropped and flags overflow.
//     valid_op              : one-cycle strobe; option/is_index are valid
//                             only while it is high.
//     resp_valid            : one-cycle verdict for the last option issued;
//                             only consumed while the feeder is waiting.
//
//   Modports:
//     master : parser/solver side (drives load_*, resp_*, solved)
//     slave  : feeder side (drives load_ready, issue, status and debug)
interface line_option_feeder_if #(
    parameter int SIZE  = 3,
    parameter int DEPTH = 64
);
    logic                     load_valid;
    logic                     load_is_index;
    logic [SIZE-1:0]          load_data;
    logic                     load_done;
    logic                     load_ready;
    logic                     started;
    logic [SIZE-1:0]          option;
    logic                     valid_op;
    logic                     is_index;
    logic                     resp_valid;
    logic                     resp_keep;
    logic                     solved;
    logic                     done;
    logic                     overflow;
    logic                     stalled;
    logic [2:0]               dbg_state;
    logic [$clog2(DEPTH):0]   dbg_count;

    modport master (
        output load_valid, load_is_index, load_data, load_done,
        output resp_valid, resp_keep, solved,
        input  load_ready, started, option, valid_op, is_index,
        input  done, overflow, stalled, dbg_state, dbg_count
    );

    modport slave (
        input  load_valid, load_is_index, load_data, load_done,
        input  resp_valid, resp_keep, solved,
        output load_ready, started, option, valid_op, is_index,
        output done, overflow, stalled, dbg_state, dbg_count
    );
endinterface

// File: rtl/line_option_feeder.sv
// line_option_feeder
//   Token queue that feeds a line solver. The board parser loads an initial
//   mix of line-index tokens and option tokens; the feeder then cycles the
//   queue: index tokens are issued and immediately recycled to the tail,
//   option tokens are issued and held until the solver says keep (recycle)
//   or drop (discard). Solving ends when the queue drains or on solved.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous, active-high reset
//     bus  : line_option_feeder_if.slave (load, issue, response, status,
//            debug state/count)
//
//   Optional feature: FEEDER_STALL_DETECT_EN. When defined, issuing index
//   token 0 marks a pass boundary; a complete pass that dropped no option
//   sets stalled and ends solving at that boundary instead of issuing.
//
//   Parameters: SIZE (>=3) token width / board edge, DEPTH (power of two).
module line_option_feeder #(
    parameter int SIZE  = 3,
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    line_option_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SIZE-1:0] option_q, option_d;
    logic            is_index_q, is_index_d;
    logic            valid_op_q, valid_op_d;
    logic            overflow_q, overflow_d;

    // Queue entry: {tag, data}, tag=1 marks a line index.
    logic [SIZE:0]   mem_q [DEPTH];
    logic            mem_we;
    logic [SIZE:0]   mem_wdata;
    logic [SIZE:0]   head;

    assign head = mem_q[rd_ptr_q];

`ifdef FEEDER_STALL_DETECT_EN
    logic seen_q, seen_d;         // first boundary has been passed
    logic dropped_q, dropped_d;   // an option was dropped in this pass
    logic stalled_q, stalled_d;
    logic boundary;

    assign boundary = head[SIZE] && (head[SIZE-1:0] == '0);
`endif

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        option_d   = option_q;
        is_index_d = is_index_q;
        valid_op_d = 1'b0;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_wdata  = head;
`ifdef FEEDER_STALL_DETECT_EN
        seen_d     = seen_q;
        dropped_d  = dropped_q;
        stalled_d  = stalled_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (bus.load_valid) begin
                    if (count_q != FULL) begin
                        mem_we    = 1'b1;
                        mem_wdata = {bus.load_is_index, bus.load_data};
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        count_d   = count_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (bus.load_done) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = bus.solved ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.solved || (count_q == '0)) begin
                    state_d = S_DONE;
`ifdef FEEDER_STALL_DETECT_EN
                end else if (boundary && seen_q && !dropped_q) begin
                    // A full pass changed nothing: further passes cannot either.
                    stalled_d = 1'b1;
                    state_d   = S_DONE;
`endif
                end else begin
                    option_d   = head[SIZE-1:0];
                    is_index_d = head[SIZE];
                    valid_op_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
`ifdef FEEDER_STALL_DETECT_EN
                    if (boundary) begin
                        seen_d    = 1'b1;
                        dropped_d = 1'b0;
                    end
`endif
                    if (head[SIZE]) begin
                        // Index tokens recycle on the same edge: count unchanged.
                        mem_we    = 1'b1;
                        mem_wdata = head;
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // solved wins over the verdict so the held option is lost.
                if (bus.solved) begin
                    state_d = S_DONE;
                end else if (bus.resp_valid) begin
                    if (bus.resp_keep) begin
                        // Room is guaranteed: this slot was freed by the pop.
                        mem_we    = 1'b1;
                        mem_wdata = {1'b0, option_q};
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        count_d   = count_q + 1'b1;
                    end
`ifdef FEEDER_STALL_DETECT_EN
                    else begin
                        dropped_d = 1'b1;
                    end
`endif
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            option_q   <= '0;
            is_index_q <= 1'b0;
            valid_op_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            option_q   <= option_d;
            is_index_q <= is_index_d;
            valid_op_q <= valid_op_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= mem_wdata;
        end
    end

`ifdef FEEDER_STALL_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q    <= 1'b0;
            dropped_q <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            seen_q    <= seen_d;
            dropped_q <= dropped_d;
            stalled_q <= stalled_d;
        end
    end

    assign bus.stalled = stalled_q;
`else
    assign bus.stalled = 1'b0;
`endif

    assign bus.load_ready = (state_q == S_LOAD) && (count_q != FULL);
    assign bus.started    = (state_q == S_START);
    assign bus.done       = (state_q == S_DONE);
    assign bus.option     = option_q;
    assign bus.is_index   = is_index_q;
    assign bus.valid_op   = valid_op_q;
    assign bus.overflow   = overflow_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_count  = count_q;
endmodule
